// File: rtl/apb_ucpd_pkg.sv
// Shared definitions for the UCPD BMC receiver: the interval counter width
// and the receiver state encoding. Also holds the 3-input majority vote
// used by the optional glitch filter (UCPD_RX_GLITCH_FILTER_EN).
package apb_ucpd_pkg;

    localparam int               CNT_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_HALF = 2'd3
    } ucpd_rx_state_e;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/apb_ucpd_rx_filt.sv
// CC line glitch filter: three samples taken on the prescaled tick, output is
// their majority. Adds up to two ticks of delay and swallows any pulse that
// is present for fewer than two ticks. Only compiled when
// UCPD_RX_GLITCH_FILTER_EN is defined; the default build has no filter.
`ifdef UCPD_RX_GLITCH_FILTER_EN
module apb_ucpd_rx_filt
    import apb_ucpd_pkg::*;
(
    input  logic ic_clk,
    input  logic ic_rst_n,
    input  logic ucpd_clk_red,
    input  logic cc_in,
    output logic cc_filt
);
    logic [2:0] r_samp;

    // Shift a new CC sample in on every prescaler tick
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_samp <= '0;
        end else if (ucpd_clk_red) begin
            r_samp <= {r_samp[1:0], cc_in};
        end
    end

    assign cc_filt = maj3(r_samp);

endmodule
`endif

// File: rtl/apb_ucpd_bmc_rx.sv
// UCPD BMC receiver. Measures the tick count between CC transitions and
// decodes biphase-mark bits: one full interval is a 0, two half intervals
// are a 1. A half followed by a full, or going idle after a lone half, is a
// coding error. Strobes are registered, one cycle after the edge is seen.
// Optional feature: UCPD_RX_GLITCH_FILTER_EN inserts a majority filter in
// front of edge detection.
module apb_ucpd_bmc_rx
    import apb_ucpd_pkg::*;
(
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             rx_en,
    input  logic             cc_in,
    input  logic             ucpd_clk_red,
    input  logic [CNT_W-1:0] bit_thr,
    input  logic [CNT_W-1:0] idle_lmt,
    output logic             rx_bit,
    output logic             rx_bit_vld,
    output logic             rx_err,
    output logic             rx_idle,
    output logic             rx_active
);
    logic             w_cc_src;
    logic             r_cc_d;
    logic             w_trans;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_idle_hit;
    ucpd_rx_state_e   r_state;
    ucpd_rx_state_e   w_state_nxt;
    logic             w_bit_nxt;
    logic             w_vld_nxt;
    logic             w_err_nxt;

`ifdef UCPD_RX_GLITCH_FILTER_EN
    apb_ucpd_rx_filt u_rx_filt (
        .ic_clk       (ic_clk),
        .ic_rst_n     (ic_rst_n),
        .ucpd_clk_red (ucpd_clk_red),
        .cc_in        (cc_in),
        .cc_filt      (w_cc_src)
    );
`else
    assign w_cc_src = cc_in;
`endif

    // Delayed copy of the CC line for edge detection
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_cc_d <= 1'b0;
        end else begin
            r_cc_d <= w_cc_src;
        end
    end

    assign w_trans    = r_cc_d ^ w_cc_src;
    // Classification uses the count reached before this edge clears it
    assign w_full     = (r_cnt > bit_thr);
    assign w_idle_hit = (r_cnt >= idle_lmt);

    // Interval counter: ticks since the last edge, saturating
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_cnt <= '0;
        end else if (!rx_en || w_trans) begin
            r_cnt <= '0;
        end else if (ucpd_clk_red && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoder state register
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: disable first, then edges, then the idle timeout
    always_comb begin
        w_state_nxt = r_state;
        if (!rx_en) begin
            w_state_nxt = ST_IDLE;
        end else if (w_trans) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SYNC;
                ST_SYNC: w_state_nxt = ST_DATA;
                ST_DATA: w_state_nxt = w_full ? ST_DATA : ST_HALF;
                default: w_state_nxt = ST_DATA;
            endcase
        end else if ((r_state != ST_IDLE) && w_idle_hit) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Output decode: status levels from state, strobe values for next cycle
    always_comb begin
        w_bit_nxt = rx_bit;
        w_vld_nxt = 1'b0;
        w_err_nxt = 1'b0;
        rx_idle   = (r_state == ST_IDLE);
        rx_active = (r_state == ST_DATA) || (r_state == ST_HALF);
        if (rx_en) begin
            if (w_trans) begin
                if ((r_state == ST_DATA) && w_full) begin
                    w_vld_nxt = 1'b1;
                    w_bit_nxt = 1'b0;
                end else if (r_state == ST_HALF) begin
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_vld_nxt = 1'b1;
                        w_bit_nxt = 1'b1;
                    end
                end
            end else if ((r_state == ST_HALF) && w_idle_hit) begin
                // A lone half interval before the line went quiet
                w_err_nxt = 1'b1;
            end
        end
    end

    // Registered bit and strobes
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            rx_bit     <= 1'b0;
            rx_bit_vld <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_bit     <= w_bit_nxt;
            rx_bit_vld <= w_vld_nxt;
            rx_err     <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_ucpd_bmc_rx.sv
// Testbench for apb_ucpd_bmc_rx: reset values, a table of directed frames,
// idle timeout, enable drop, mid-frame reset and randomized CC waveforms
// checked against an interval-level BMC decoding model.
module tb_apb_ucpd_bmc_rx;

    localparam int NR = 1500;

    logic       ic_clk = 1'b0;
    logic       ic_rst_n;
    logic       rx_en;
    logic       cc_in;
    logic       ucpd_clk_red;
    logic [6:0] bit_thr;
    logic [6:0] idle_lmt;
    logic       rx_bit;
    logic       rx_bit_vld;
    logic       rx_err;
    logic       rx_idle;
    logic       rx_active;

    apb_ucpd_bmc_rx dut (
        .ic_clk       (ic_clk),
        .ic_rst_n     (ic_rst_n),
        .rx_en        (rx_en),
        .cc_in        (cc_in),
        .ucpd_clk_red (ucpd_clk_red),
        .bit_thr      (bit_thr),
        .idle_lmt     (idle_lmt),
        .rx_bit       (rx_bit),
        .rx_bit_vld   (rx_bit_vld),
        .rx_err       (rx_err),
        .rx_idle      (rx_idle),
        .rx_active    (rx_active)
    );

    always #5 ic_clk = ~ic_clk;

    typedef struct packed {
        logic [6:0]      thr;
        logic [2:0]      ng;
        logic [5:0][7:0] gaps;
        logic [3:0]      nb;
        logic [7:0]      bits;
        logic [3:0]      nerr;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t_last = 0;
    int         n_vld, n_err, nbits, last_vld_cyc, last_err_cyc;
    logic [7:0] bits_acc;
    bit         both_seen = 1'b0;
    logic       cc_lvl = 1'b0;

    logic       cc_arr [NR];
    logic       tk_arr [NR];
    logic [2:0] exp_ev [NR+1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_vld = 0; n_err = 0; nbits = 0; bits_acc = '0;
        last_vld_cyc = -1; last_err_cyc = -1;
    endtask

    // one clock: drive inputs after the edge, sample strobes on the falling edge
    task automatic step(input logic cc, input logic en);
        @(posedge ic_clk);
        #1;
        cc_in = cc; rx_en = en; ucpd_clk_red = 1'b1;
        cyc++;
        @(negedge ic_clk);
        if (rx_bit_vld === 1'b1) begin
            if (nbits < 8) bits_acc[nbits] = rx_bit;
            nbits++; n_vld++; last_vld_cyc = cyc;
        end
        if (rx_err === 1'b1) begin
            n_err++; last_err_cyc = cyc;
        end
        if (rx_bit_vld === 1'b1 && rx_err === 1'b1) both_seen = 1'b1;
    endtask

    function automatic vec_t mk(input int thr, input int ng, input int g0, input int g1,
                                input int g2, input int g3, input int g4, input int g5,
                                input int nb, input int bits, input int nerr);
        vec_t v;
        v.thr = 7'(thr); v.ng = 3'(ng);
        v.gaps[0] = 8'(g0); v.gaps[1] = 8'(g1); v.gaps[2] = 8'(g2);
        v.gaps[3] = 8'(g3); v.gaps[4] = 8'(g4); v.gaps[5] = 8'(g5);
        v.nb = 4'(nb); v.bits = 8'(bits); v.nerr = 4'(nerr);
        return v;
    endfunction

    // first edge leaves IDLE, each gap (in cycles, tick every cycle) ends in an edge
    task automatic send_gaps(input vec_t v);
        cc_lvl = ~cc_lvl; step(cc_lvl, 1'b1); t_last = cyc;
        for (int i = 0; i < int'(v.ng); i++) begin
            repeat (int'(v.gaps[i]) - 1) step(cc_lvl, 1'b1);
            cc_lvl = ~cc_lvl; step(cc_lvl, 1'b1); t_last = cyc;
        end
    endtask

    // ticks seen strictly between edge cycle t and cycle c, capped at 127
    function automatic int ticks_between(input int t, input int c);
        int s = 0;
        for (int i = t + 1; i < c; i++) if (tk_arr[i]) s++;
        return (s > 127) ? 127 : s;
    endfunction

    // interval-level model: walk the edges of the CC waveform and decode
    task automatic build_model(input int thr, input int lmt);
        logic prev = 1'b0;
        bit engaged = 1'b0, locked = 1'b0, half = 1'b0;
        int lastt = -1;
        int gap;
        for (int c = 0; c <= NR; c++) exp_ev[c] = 3'b000;
        for (int c = 0; c < NR; c++) begin
            if (cc_arr[c] != prev) begin
                if (!engaged) begin
                    engaged = 1'b1; locked = 1'b0; half = 1'b0;
                end else begin
                    gap = ticks_between(lastt, c);
                    if (!locked) locked = 1'b1;
                    else if (!half) begin
                        if (gap > thr) exp_ev[c+1] = 3'b100; else half = 1'b1;
                    end else begin
                        half = 1'b0;
                        exp_ev[c+1] = (gap > thr) ? 3'b010 : 3'b101;
                    end
                end
                lastt = c;
            end else if (engaged && ticks_between(lastt, c) >= lmt) begin
                if (half) exp_ev[c+1] = 3'b010;
                engaged = 1'b0; locked = 1'b0; half = 1'b0;
            end
            prev = cc_arr[c];
        end
    endtask

    task automatic run_random(input int run, input int thr, input int lmt, input int tick_pct);
        logic lvl = 1'b0;
        int c = 0;
        int gap;
        bit_thr = 7'(thr); idle_lmt = 7'(lmt);
        cc_lvl = 1'b0;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        while (c < NR) begin
            if ($urandom_range(0, 15) == 0) gap = $urandom_range(2 * lmt, 2 * lmt + 20);
            else gap = $urandom_range(2, 3 * thr);
            for (int i = 0; i < gap && c < NR; i++) begin
                cc_arr[c] = lvl; c++;
            end
            lvl = ~lvl;
        end
        for (int i = 0; i < NR; i++)
            tk_arr[i] = (tick_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < tick_pct);
        build_model(thr, lmt);
        for (int i = 0; i < NR; i++) begin
            @(posedge ic_clk);
            #1;
            cc_in = cc_arr[i]; ucpd_clk_red = tk_arr[i]; rx_en = 1'b1;
            @(negedge ic_clk);
            if (rx_bit_vld === 1'b1 && rx_err === 1'b1) both_seen = 1'b1;
            chk($sformatf("rand%0d cyc%0d {vld,err,bit}", run, i),
                {rx_bit_vld, rx_err, rx_bit & rx_bit_vld}, exp_ev[i]);
        end
        cc_lvl = cc_arr[NR-1];
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = mk(12, 5, 16, 16, 8, 8, 16, 0, 3, 3'b010, 0);
        tbl[1] = mk(12, 3, 16, 8, 16, 0, 0, 0, 0, 0, 1);
        tbl[2] = mk(12, 4, 16, 14, 13, 13, 0, 0, 2, 2'b10, 0);
        tbl[3] = mk(5, 4, 10, 7, 6, 6, 0, 0, 2, 2'b10, 0);
        tbl[4] = mk(12, 5, 20, 8, 8, 8, 8, 0, 2, 2'b11, 0);
        tbl[5] = mk(12, 2, 6, 16, 0, 0, 0, 0, 1, 1'b0, 0);

        ic_rst_n = 1'b0; rx_en = 1'b0; cc_in = 1'b0; ucpd_clk_red = 1'b0;
        bit_thr = 7'd12; idle_lmt = 7'd40;
        clear_counts();
        repeat (3) @(negedge ic_clk);
        chk("reset rx_bit", rx_bit, 0);
        chk("reset rx_bit_vld", rx_bit_vld, 0);
        chk("reset rx_err", rx_err, 0);
        chk("reset rx_idle", rx_idle, 1);
        chk("reset rx_active", rx_active, 0);
        ic_rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b1);
        chk("post-reset no edge rx_idle", rx_idle, 1);
        chk("post-reset no strobes", n_vld + n_err, 0);

`ifdef UCPD_RX_GLITCH_FILTER_EN
        clear_counts();
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        chk("filter 1-tick pulse rx_idle", rx_idle, 1);
        chk("filter 1-tick pulse strobes", n_vld + n_err, 0);
        repeat (6) step(1'b1, 1'b1);
        chk("filter level change leaves idle", rx_idle, 0);
        chk("filter level change rx_active", rx_active, 0);
`else
        // table of directed frames, tick every cycle, idle limit 40
        for (int i = 0; i < 6; i++) begin
            bit_thr = tbl[i].thr; idle_lmt = 7'd40;
            step(cc_lvl, 1'b0);
            clear_counts();
            send_gaps(tbl[i]);
            step(cc_lvl, 1'b1); step(cc_lvl, 1'b1);
            chk($sformatf("vec%0d bit count", i), nbits, tbl[i].nb);
            chk($sformatf("vec%0d bits", i), bits_acc & ((8'd1 << tbl[i].nb) - 8'd1), tbl[i].bits);
            chk($sformatf("vec%0d err count", i), n_err, tbl[i].nerr);
            chk($sformatf("vec%0d rx_active", i), rx_active, 1);
            chk($sformatf("vec%0d rx_idle", i), rx_idle, 0);
            if (tbl[i].nerr != 0) chk($sformatf("vec%0d err latency", i), last_err_cyc, t_last + 1);
            else chk($sformatf("vec%0d vld latency", i), last_vld_cyc, t_last + 1);
        end

        // idle timeout while waiting for the second half of a 1
        bit_thr = 7'd12; idle_lmt = 7'd40;
        step(cc_lvl, 1'b0);
        clear_counts();
        send_gaps(mk(12, 2, 16, 8, 0, 0, 0, 0, 0, 0, 0));
        repeat (45) step(cc_lvl, 1'b1);
        chk("idle-in-half err count", n_err, 1);
        chk("idle-in-half vld count", n_vld, 0);
        chk("idle-in-half err cycle", last_err_cyc, t_last + 42);
        chk("idle-in-half rx_idle", rx_idle, 1);
        chk("idle-in-half rx_active", rx_active, 0);

        // enable dropped mid-frame together with an edge, then re-enabled
        step(cc_lvl, 1'b0);
        send_gaps(mk(12, 2, 16, 16, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) step(cc_lvl, 1'b1);
        clear_counts();
        cc_lvl = ~cc_lvl; step(cc_lvl, 1'b0);
        chk("disable same-cycle rx_active", rx_active, 1);
        step(cc_lvl, 1'b0);
        chk("disable next-cycle rx_idle", rx_idle, 1);
        chk("disable next-cycle rx_active", rx_active, 0);
        repeat (3) step(cc_lvl, 1'b0);
        chk("disable no strobes", n_vld + n_err, 0);
        cc_lvl = ~cc_lvl; step(cc_lvl, 1'b1);
        step(cc_lvl, 1'b1);
        chk("re-enable sync rx_idle", rx_idle, 0);
        chk("re-enable sync rx_active", rx_active, 0);
        repeat (14) step(cc_lvl, 1'b1);
        cc_lvl = ~cc_lvl; step(cc_lvl, 1'b1);
        step(cc_lvl, 1'b1);
        chk("re-enable data rx_active", rx_active, 1);
        chk("re-enable sync discarded", n_vld + n_err, 0);

        // randomized waveforms against the decoding model
        run_random(1, 12, 40, 100);
        run_random(2, $urandom_range(6, 16), $urandom_range(35, 70), 75);

        // asynchronous reset while a bit strobe is high
        bit_thr = 7'd12; idle_lmt = 7'd40;
        step(cc_lvl, 1'b0);
        send_gaps(mk(12, 4, 16, 16, 8, 8, 0, 0, 0, 0, 0));
        @(posedge ic_clk);
        #2;
        chk("pre-reset rx_bit_vld", rx_bit_vld, 1);
        chk("pre-reset rx_bit", rx_bit, 1);
        ic_rst_n = 1'b0; cc_in = 1'b0; cc_lvl = 1'b0;
        #1;
        chk("mid-frame reset rx_bit", rx_bit, 0);
        chk("mid-frame reset rx_bit_vld", rx_bit_vld, 0);
        chk("mid-frame reset rx_err", rx_err, 0);
        chk("mid-frame reset rx_idle", rx_idle, 1);
        chk("mid-frame reset rx_active", rx_active, 0);
        repeat (2) @(negedge ic_clk);
        chk("held reset strobes", {rx_bit_vld, rx_err}, 0);
        ic_rst_n = 1'b1;
`endif

        chk("vld and err never together", both_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_ucpd_bmc_rx.md
APB_UCPD_BMC_RX -- requirements
Module: apb_ucpd_bmc_rx

Interface
REQ-001 SHALL have port ic_clk  input  1  processor clock; the only clock in the block.
REQ-002 SHALL have port ic_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port rx_en  input  1  receiver enable; 0 forces IDLE.
REQ-004 SHALL have port cc_in  input  1  CC line, already synchronized to ic_clk.
REQ-005 SHALL have port ucpd_clk_red  input  1  one-cycle prescaled tick from the clock generator; counting timebase.
REQ-006 SHALL have port bit_thr  input  7  tick threshold separating a half-bit interval from a full-bit interval.
REQ-007 SHALL have port idle_lmt  input  7  tick count without a transition that declares the line idle.
REQ-008 SHALL have port rx_bit  output  1  decoded bit value.
REQ-009 SHALL have port rx_bit_vld  output  1  one-cycle strobe qualifying rx_bit.
REQ-010 SHALL have port rx_err  output  1  one-cycle strobe on a BMC coding violation.
REQ-011 SHALL have port rx_idle  output  1  level; the line is idle.
REQ-012 SHALL have port rx_active  output  1  level; the receiver is decoding.

Function
REQ-013 SHALL detect a transition as cc_d XOR cc_in, where cc_d is cc_in registered on ic_clk.
REQ-014 SHALL hold a 7-bit interval counter that:
- increments on ucpd_clk_red;
- saturates at 127;
- clears on every detected transition.
REQ-015 SHALL implement states IDLE, SYNC, DATA and HALF.
REQ-016 SHALL transition IDLE -> SYNC on the first transition while rx_en=1, with no bit output.
REQ-017 SHALL transition SYNC -> DATA on the next transition, discarding that interval.
REQ-018 SHALL classify each transition in DATA or HALF by the counter value before clearing:
- counter > bit_thr is a full interval;
- counter <= bit_thr is a half interval.
REQ-019 SHALL, in DATA:
- on a full interval, emit rx_bit=0 with rx_bit_vld=1 and stay in DATA;
- on a half interval, go to HALF with no output.
REQ-020 SHALL, in HALF:
- on a half interval, emit rx_bit=1 with rx_bit_vld=1 and return to DATA;
- on a full interval, pulse rx_err and return to DATA with no bit output.
REQ-021 SHALL emit rx_bit_vld and rx_err on the ic_clk cycle after the edge-detect cycle, giving a latency of 1 cycle.
REQ-022 SHALL, in any non-IDLE state, go to IDLE and set rx_idle=1 when counter >= idle_lmt.
REQ-023 SHALL, when going to IDLE from HALF, pulse rx_err.
REQ-024 SHALL clear rx_idle on the transition that leaves IDLE.
REQ-025 SHALL drive rx_active=1 in the DATA and HALF states only.
REQ-026 SHALL give rx_en=0 priority over all events: next state IDLE, counter cleared, no strobes.
REQ-027 SHALL let a transition win over the idle limit when both occur in the same cycle.
REQ-028 SHALL never assert rx_bit_vld and rx_err in the same cycle.

Reset
REQ-029 SHALL, on ic_rst_n=0, force state IDLE, counter=0 and cc_d=0.
REQ-030 SHALL, on ic_rst_n=0, force rx_bit=0, rx_bit_vld=0, rx_err=0, rx_idle=1 and rx_active=0.
REQ-031 SHALL give a reset asserted mid-frame immediate effect and SHALL NOT generate any strobe.

Configuration
REQ-032 SHALL, when UCPD_RX_GLITCH_FILTER_EN is defined, pass cc_in through a 3-sample majority filter clocked on ucpd_clk_red before edge detection.
REQ-033 SHALL, with UCPD_RX_GLITCH_FILTER_EN defined, add up to 2 ticks of latency and reject pulses shorter than 2 ticks.
REQ-034 SHALL, without UCPD_RX_GLITCH_FILTER_EN, feed cc_in directly to edge detection.

Structure
REQ-035 SHALL place the state encoding (IDLE/SYNC/DATA/HALF) and the counter width constant (7) in the shared package apb_ucpd_pkg.
REQ-036 SHALL implement the majority filter as sub-module apb_ucpd_rx_filt, instantiated only under UCPD_RX_GLITCH_FILTER_EN.

Verification
REQ-037 SHALL cover: ucpd_clk_red every cycle, bit_thr=12, transition intervals 16 (SYNC), 16, 8, 8, 16 -> bits 0, 1, 0 with rx_bit_vld, no rx_err.
REQ-038 SHALL cover: in DATA, interval 8 then interval 16 -> one rx_err pulse, no rx_bit_vld, state DATA.
REQ-039 SHALL cover: idle_lmt=40, no transition for 40 ticks in HALF -> rx_err pulse, rx_idle=1, rx_active=0.
REQ-040 SHALL cover: rx_en deasserted mid-frame -> next cycle IDLE, no strobes; re-enable with a transition -> SYNC.
REQ-041 SHALL cover: ic_rst_n asserted during DATA -> all outputs at reset values immediately.
REQ-042 SHALL cover, with UCPD_RX_GLITCH_FILTER_EN defined: a 1-tick cc_in pulse -> no transition detected, no strobe.
